// File: rtl/launchpad_key_scan.sv
// launchpad_key_scan: per-pad synchroniser and debouncer with a press/release event queue.
// Optional feature macro: KEY_SCAN_RELEASE_EV_EN (queue release events as well as presses).
module launchpad_key_scan #(
    parameter int unsigned NPADS      = 8,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPADS-1:0] pad_raw,
    output logic [NPADS-1:0] key_level,
    output logic [NPADS-1:0] key_press,
    output logic             ev_valid,
    output logic [2:0]       ev_code,
    output logic             ev_rel,
    input  logic             ev_ready,
    output logic             ev_ovf
);

    localparam int unsigned   CntW     = $clog2(DEB_CYCLES);
    localparam int unsigned   PtrW     = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);
    localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);
`ifdef KEY_SCAN_RELEASE_EV_EN
    localparam int unsigned   EntryW   = 4;  // {rel, code}
`else
    localparam int unsigned   EntryW   = 3;  // code only
`endif

    logic [NPADS-1:0]  r_sync1, r_sync2, r_stable, r_press, r_pend_p;
    logic [CntW-1:0]   r_cnt [NPADS];
    logic [NPADS-1:0]  w_accept, w_rise, w_grant_p, w_pend_p_d;
    logic              w_lost;
    logic              w_push, w_pop;
    logic [EntryW-1:0] w_push_data, w_head;
    logic [EntryW-1:0] r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wptr, r_rptr;
    logic [PtrW:0]     r_count;
    logic              r_ovf;
`ifdef KEY_SCAN_RELEASE_EV_EN
    // r_order[i] = 1 means the pending release of pad i is older than its pending press.
    logic [NPADS-1:0]  r_pend_r, r_order;
    logic [NPADS-1:0]  w_fall, w_grant_r, w_pend_r_d, w_order_d;
`endif

    // Two-flop synchroniser for the asynchronous pad contacts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A level is accepted once it has differed from the stable value for DEB_CYCLES cycles.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NPADS; i++) begin
            w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CntMax);
        end
    end

    assign w_rise = w_accept & r_sync2;
`ifdef KEY_SCAN_RELEASE_EV_EN
    assign w_fall = w_accept & ~r_sync2;
`endif

    // Debounce counters, stable levels and the press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= '0;
            r_press  <= '0;
            for (int i = 0; i < NPADS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_press  <= w_rise;
            r_stable <= r_stable ^ w_accept;
            for (int i = 0; i < NPADS; i++) begin
                if ((r_sync2[i] == r_stable[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CntW'(1);
                end
            end
        end
    end

    // Arbiter: lowest pending pad wins; within a pad the older event type goes first.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        w_grant_p   = '0;
`ifdef KEY_SCAN_RELEASE_EV_EN
        w_grant_r   = '0;
`endif
        if (r_count < FifoFull) begin
            for (int i = 0; i < NPADS; i++) begin
                if (!w_push) begin
`ifdef KEY_SCAN_RELEASE_EV_EN
                    if (r_pend_p[i] || r_pend_r[i]) begin
                        w_push = 1'b1;
                        if (r_pend_r[i] && (!r_pend_p[i] || r_order[i])) begin
                            w_grant_r[i] = 1'b1;
                            w_push_data  = {1'b1, 3'(i)};
                        end else begin
                            w_grant_p[i] = 1'b1;
                            w_push_data  = {1'b0, 3'(i)};
                        end
                    end
`else
                    if (r_pend_p[i]) begin
                        w_push       = 1'b1;
                        w_grant_p[i] = 1'b1;
                        w_push_data  = 3'(i);
                    end
`endif
                end
            end
        end
    end

    // Pending-bit next state; a change that finds its bit already set is lost.
    always_comb begin
        w_pend_p_d = (r_pend_p & ~w_grant_p) | (w_rise & ~r_pend_p);
        w_lost     = |(w_rise & r_pend_p);
`ifdef KEY_SCAN_RELEASE_EV_EN
        w_pend_r_d = (r_pend_r & ~w_grant_r) | (w_fall & ~r_pend_r);
        w_lost     = w_lost | (|(w_fall & r_pend_r));
        w_order_d  = r_order;
        for (int i = 0; i < NPADS; i++) begin
            if (w_rise[i] && !r_pend_p[i]) begin
                w_order_d[i] = w_pend_r_d[i];    // a release still waiting is older
            end else if (w_fall[i] && !r_pend_r[i]) begin
                w_order_d[i] = !w_pend_p_d[i];   // a press still waiting is older
            end
        end
`endif
    end

    // Pending bits, order bits and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_p <= '0;
            r_ovf    <= 1'b0;
`ifdef KEY_SCAN_RELEASE_EV_EN
            r_pend_r <= '0;
            r_order  <= '0;
`endif
        end else begin
            r_pend_p <= w_pend_p_d;
            r_ovf    <= r_ovf | w_lost;
`ifdef KEY_SCAN_RELEASE_EV_EN
            r_pend_r <= w_pend_r_d;
            r_order  <= w_order_d;
`endif
        end
    end

    assign w_pop = ev_valid & ev_ready;

    // Event storage; contents are only visible while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PtrW + 1)'(1);
                2'b01:   r_count <= r_count - (PtrW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign key_level = r_stable;
    assign key_press = r_press;
    assign ev_valid  = (r_count != '0);
    assign w_head    = ev_valid ? r_mem[r_rptr] : '0;
    assign ev_code   = w_head[2:0];
`ifdef KEY_SCAN_RELEASE_EV_EN
    assign ev_rel    = w_head[3];
`else
    assign ev_rel    = 1'b0;
`endif
    assign ev_ovf    = r_ovf;

endmodule

// File: tb/tb_launchpad_key_scan.sv
// Bench for launchpad_key_scan: cycle model from the debounce/queue rules plus directed scenarios.
`timescale 1ns/1ps
module tb_launchpad_key_scan;

    localparam int NP    = 8;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NP-1:0] pad_raw = '0;
    logic          ev_ready = 1'b0;
    logic [NP-1:0] key_level, key_press;
    logic          ev_valid, ev_rel, ev_ovf;
    logic [2:0]    ev_code;

    always #5 clk = ~clk;

    launchpad_key_scan #(
        .NPADS      (NP),
        .DEB_CYCLES (DEB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pad_raw   (pad_raw),
        .key_level (key_level),
        .key_press (key_press),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_rel    (ev_rel),
        .ev_ready  (ev_ready),
        .ev_ovf    (ev_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level flips once the last DEB synchronised samples (raw samples 2..DEB+1 edges old)
    // all disagree with it. Each pad keeps an age-ordered list of pending event types.
    bit [15:0]     hist [NP];
    bit [NP-1:0]   m_lvl = '0, m_press = '0, mr, mf, had_p, had_r;
    int            pn [NP];
    bit            pfirst [NP], psecond [NP];
    bit [3:0]      m_fifo [$];
    bit            m_ovf = 1'b0, m_push, alld;
    bit [3:0]      m_pdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                hist[p] = '0; pn[p] = 0; pfirst[p] = 0; psecond[p] = 0;
            end
            m_lvl = '0; m_press = '0; m_ovf = 1'b0;
            m_fifo.delete();
        end else begin
            for (int p = 0; p < NP; p++) begin
                hist[p] = {hist[p][14:0], pad_raw[p]};
                alld = 1'b1;
                for (int j = 2; j <= DEB + 1; j++) if (hist[p][j] == m_lvl[p]) alld = 1'b0;
                mr[p] = alld & ~m_lvl[p];
                mf[p] = alld & m_lvl[p];
                had_p[p] = (pn[p] > 0 && pfirst[p] == 0) || (pn[p] > 1 && psecond[p] == 0);
                had_r[p] = (pn[p] > 0 && pfirst[p] == 1) || (pn[p] > 1 && psecond[p] == 1);
            end
            m_push = 1'b0; m_pdata = '0;
            if (m_fifo.size() < DEPTH) begin
                for (int p = 0; p < NP; p++) begin
                    if (!m_push && pn[p] > 0) begin
                        m_push = 1'b1;
                        m_pdata = {pfirst[p], 3'(p)};
                        pfirst[p] = psecond[p];
                        pn[p]--;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (mr[p]) begin
                    if (had_p[p]) m_ovf = 1'b1;
                    else begin
                        if (pn[p] == 0) pfirst[p] = 1'b0; else psecond[p] = 1'b0;
                        pn[p]++;
                    end
                end
`ifdef KEY_SCAN_RELEASE_EV_EN
                if (mf[p]) begin
                    if (had_r[p]) m_ovf = 1'b1;
                    else begin
                        if (pn[p] == 0) pfirst[p] = 1'b1; else psecond[p] = 1'b1;
                        pn[p]++;
                    end
                end
`endif
            end
            if (m_fifo.size() > 0 && ev_ready) void'(m_fifo.pop_front());
            if (m_push) m_fifo.push_back(m_pdata);
            m_lvl   = m_lvl ^ (mr | mf);
            m_press = mr;
        end
    end

    // Per-cycle comparison against the model.
    bit [3:0] exp_head;
    always @(posedge clk) begin
        #2;
        exp_head = (m_fifo.size() > 0) ? m_fifo[0] : 4'h0;
        check("key_level", 32'(key_level), 32'(m_lvl));
        check("key_press", 32'(key_press), 32'(m_press));
        check("ev_valid", 32'(ev_valid), 32'(m_fifo.size() > 0));
        check("ev_code", 32'(ev_code), 32'(exp_head[2:0]));
        check("ev_rel", 32'(ev_rel), 32'(exp_head[3]));
        check("ev_ovf", 32'(ev_ovf), 32'(m_ovf));
    end

    // Log of events actually accepted from the DUT.
    int       cyc = 0;
    bit [3:0] got [$];
    int       got_cyc [$];
    bit [3:0] exp_ev [$];

    always @(posedge clk) begin
        cyc++;
        if (rst && ev_valid && ev_ready) begin
            got.push_back({ev_rel, ev_code});
            got_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        got.delete(); got_cyc.delete(); exp_ev.delete();
    endtask

    task automatic check_events(input string name);
        check({name, "_count"}, 32'(got.size()), 32'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size(); i++) begin
            if (i < got.size()) check({name, "_event"}, 32'(got[i]), 32'(exp_ev[i]));
        end
    endtask

    initial begin
        idle(2);
        check("reset_level", 32'(key_level), 0);
        check("reset_valid", 32'(ev_valid), 0);
        check("reset_ovf", 32'(ev_ovf), 0);
        rst = 1'b1;

        // Clean press of pad 3: level at edge 6, event visible for one cycle after.
        @(negedge clk);
        clear_log();
        pad_raw[3] = 1'b1; ev_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("t1_level_edge5", 32'(key_level[3]), 0);
        @(posedge clk); #1;
        check("t1_level_edge6", 32'(key_level[3]), 1);
        check("t1_press_edge6", 32'(key_press[3]), 1);
        @(posedge clk); #1;
        check("t1_press_edge7", 32'(key_press[3]), 0);
        check("t1_valid_edge7", 32'(ev_valid), 1);
        check("t1_code_edge7", 32'(ev_code), 3);
        check("t1_rel_edge7", 32'(ev_rel), 0);
        @(posedge clk); #1;
        check("t1_valid_edge8", 32'(ev_valid), 0);
        idle(14);
        exp_ev.push_back(4'h3);
        check_events("t1");
        pad_raw = '0; idle(20); clear_log();

        // Bounce on pad 0 then a steady press: exactly one press event.
        pad_raw[0] = 1'b1; idle(1);
        pad_raw[0] = 1'b0; idle(1);
        pad_raw[0] = 1'b1; idle(1);
        pad_raw[0] = 1'b0; idle(1);
        pad_raw[0] = 1'b1; idle(15);
        exp_ev.push_back(4'h0);
        check_events("t2");
        check("t2_ovf", 32'(ev_ovf), 0);
        pad_raw = '0; idle(20); clear_log();

        // Pads 5, 1, 6 together: popped 1, 5, 6 on consecutive cycles.
        pad_raw = 8'b0110_0010; idle(15);
        exp_ev.push_back(4'h1); exp_ev.push_back(4'h5); exp_ev.push_back(4'h6);
        check_events("t3");
        if (got_cyc.size() == 3) begin
            check("t3_consec_a", 32'(got_cyc[1] - got_cyc[0]), 1);
            check("t3_consec_b", 32'(got_cyc[2] - got_cyc[1]), 1);
        end
        pad_raw = '0; idle(20); clear_log();

        // Backpressure: 0..3 queued, 4 and 5 pending; pad 4 release and re-press overflows.
        ev_ready = 1'b0;
        pad_raw = 8'h3F; idle(12);
        check("t4_valid_stall", 32'(ev_valid), 1);
        check("t4_code_stall", 32'(ev_code), 0);
        pad_raw[4] = 1'b0; idle(8);
        pad_raw[4] = 1'b1; idle(8);
        check("t4_ovf", 32'(ev_ovf), 1);
        check("t4_code_hold", 32'(ev_code), 0);
        ev_ready = 1'b1; idle(15);
        exp_ev.push_back(4'h0); exp_ev.push_back(4'h1);
        exp_ev.push_back(4'h2); exp_ev.push_back(4'h3);
        exp_ev.push_back(4'h4);
`ifdef KEY_SCAN_RELEASE_EV_EN
        exp_ev.push_back(4'hC);  // pad 4 release is a lower index than pad 5
`endif
        exp_ev.push_back(4'h5);
        check_events("t4");
        pad_raw = '0; idle(25); clear_log();

        // Press then release of pad 7.
        pad_raw[7] = 1'b1; idle(12);
        pad_raw[7] = 1'b0; idle(12);
        exp_ev.push_back(4'h7);
`ifdef KEY_SCAN_RELEASE_EV_EN
        exp_ev.push_back(4'hF);
`endif
        check_events("t5");
        idle(5); clear_log();

        // Reset with three events queued and pad 3 mid-debounce.
        ev_ready = 1'b0;
        pad_raw = 8'h07; idle(12);
        check("t6_valid_before", 32'(ev_valid), 1);
        pad_raw[3] = 1'b1; idle(3);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_level", 32'(key_level), 0);
        check("t6_rst_press", 32'(key_press), 0);
        check("t6_rst_valid", 32'(ev_valid), 0);
        check("t6_rst_code", 32'(ev_code), 0);
        check("t6_rst_rel", 32'(ev_rel), 0);
        check("t6_rst_ovf", 32'(ev_ovf), 0);
        @(negedge clk);
        clear_log();
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("t6_level_edge5", 32'(key_level), 0);
        @(posedge clk); #1;
        check("t6_level_edge6", 32'(key_level), 32'h0F);
        ev_ready = 1'b1; idle(10);
        exp_ev.push_back(4'h0); exp_ev.push_back(4'h1);
        exp_ev.push_back(4'h2); exp_ev.push_back(4'h3);
        check_events("t6");
        pad_raw = '0; idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
